// File: rtl/xor_parity_arbiter.sv
// Bit-serial even-parity engine shared by two requesters under round-robin
// arbitration. A single two-input XOR folds the captured word into an
// accumulator one bit per clock, LSB first.

// Shared two-input XOR primitive.
module xor2 (
  input  logic x,
  input  logic y,
  output logic z
);
  assign z = x ^ y;
endmodule

module xor_parity_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic             out_id,
  output logic             busy
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               acc_q;
  logic               id_q;
  logic               last_grant_q;
  logic               grant1, grant0, any_valid, last_bit, xor_z;

  // Round-robin pick: a lone requester wins, otherwise the one not served last.
  assign grant1    = req1_valid && (!req0_valid || !last_grant_q);
  assign grant0    = req0_valid && !grant1;
  assign any_valid = req0_valid || req1_valid;
  assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));

  xor2 u_xor (
    .x (acc_q),
    .y (shreg_q[0]),
    .z (xor_z)
  );

  // Handshakes only in IDLE; suppressed while reset is asserted since no
  // transfer can happen on that edge.
  assign req0_ready = (state_q == IDLE) && grant0 && !rst;
  assign req1_ready = (state_q == IDLE) && grant1 && !rst;
  assign out_valid  = (state_q == DONE);
  assign out_parity = (state_q == DONE) && acc_q;
  assign out_id     = (state_q == DONE) && id_q;
  assign busy       = (state_q != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: accept, shift WIDTH bits, hold result until consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid) state_d = SHIFT;
      SHIFT:   if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on accept, fold one bit per SHIFT edge, record the
  // served requester when its result is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q      <= '0;
      cnt_q        <= '0;
      acc_q        <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (any_valid) begin
          shreg_q <= grant1 ? req1_data : req0_data;
          acc_q   <= 1'b0;
          cnt_q   <= '0;
          id_q    <= grant1;
        end
        SHIFT: begin
          acc_q   <= xor_z;
          shreg_q <= shreg_q >> 1;
          cnt_q   <= cnt_q + CNT_W'(1);
        end
        DONE: if (out_ready) last_grant_q <= id_q;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_xor_parity_arbiter.sv
// Directed bench for xor_parity_arbiter: a transaction-level model predicts
// every output each cycle, and directed sequences pin hand-computed results.
module tb_xor_parity_arbiter;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic [WIDTH-1:0] req0_data = '0, req1_data = '0;
  logic             req0_ready, req1_ready;
  logic             out_valid, out_parity, out_id, busy;
  logic             out_ready = 1'b0;

  int tests = 0;
  int fails = 0;
  bit en = 1'b0;

  xor_parity_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_parity (out_parity),
    .out_id     (out_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction model: a job is in flight from acceptance until consumed;
  // its result is visible once WIDTH edges have elapsed after acceptance.
  bit m_busy = 0, m_id = 0, m_par = 0, m_last = 1;
  int m_t = 0;

  function automatic bit pick1(bit v0, bit v1, bit lg);
    return v1 && (!v0 || !lg);
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_t = 0; m_last = 1;
    end else if (!m_busy) begin
      if (req0_valid || req1_valid) begin
        m_id   = pick1(req0_valid, req1_valid, m_last);
        m_par  = m_id ? ^req1_data : ^req0_data;
        m_busy = 1;
        m_t    = 0;
      end
    end else if (m_t >= WIDTH) begin
      if (out_ready) begin m_busy = 0; m_last = m_id; end
    end else begin
      m_t++;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial forever begin
    bit ev, w1;
    @(negedge clk);
    if (en) begin
      ev = m_busy && (m_t >= WIDTH);
      w1 = pick1(req0_valid, req1_valid, m_last);
      chk("cyc out_valid",  out_valid,  ev);
      chk("cyc busy",       busy,       m_busy);
      chk("cyc out_parity", out_parity, ev && m_par);
      chk("cyc out_id",     out_id,     ev && m_id);
      chk("cyc req0_ready", req0_ready, !m_busy && !rst && req0_valid && !w1);
      chk("cyc req1_ready", req1_ready, !m_busy && !rst && w1);
      chk("cyc ready_excl", req0_ready && req1_ready, 1'b0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Wait (bounded) for out_valid; n counts edges including the one just taken.
  task automatic wait_result(input string nm, output int n);
    n = 1;
    while (!out_valid && n < 40) begin tick(1); n++; end
    if (!out_valid) chk({nm, " timeout"}, 0, 1);
  endtask

  task automatic run_word(input bit which, input logic [7:0] d, input bit exp_par, input string nm);
    int n;
    if (which) begin req1_valid = 1; req1_data = d; end
    else       begin req0_valid = 1; req0_data = d; end
    out_ready = 1;
    #1;
    chk({nm, " ready"}, which ? req1_ready : req0_ready, 1'b1);
    tick(1);
    req0_valid = 0; req1_valid = 0;
    wait_result(nm, n);
    chk({nm, " latency"}, n, WIDTH + 1);
    chk({nm, " parity"}, out_parity, exp_par);
    chk({nm, " id"}, out_id, which);
    tick(1);
    chk({nm, " idle valid"}, out_valid, 1'b0);
    chk({nm, " idle busy"}, busy, 1'b0);
  endtask

  initial begin
    int n;
    bit exp_ids [4] = '{0, 1, 0, 1};
    tick(2);
    en = 1;
    rst = 0;
    #1;
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset parity", out_parity, 1'b0);

    run_word(0, 8'hA5, 1'b0, "req0 A5");
    run_word(1, 8'h07, 1'b1, "req1 07");

    // Contention and fairness from a fresh reset.
    rst = 1; tick(1); rst = 0;
    req0_valid = 1; req0_data = 8'h01;
    req1_valid = 1; req1_data = 8'h03;
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      wait_result("fair", n);
      chk("fair id", out_id, exp_ids[k]);
      chk("fair parity", out_parity, exp_ids[k] ? 1'b0 : 1'b1);
      if (k == 3) begin req0_valid = 0; req1_valid = 0; end
    end
    tick(1);

    // Backpressure: result frozen while out_ready is low.
    out_ready = 0;
    req0_valid = 1; req0_data = 8'h80;
    req1_valid = 1; req1_data = 8'h00;
    tick(1);
    req0_valid = 0;
    wait_result("bp", n);
    for (int k = 0; k < 5; k++) begin
      chk("bp valid", out_valid, 1'b1);
      chk("bp parity", out_parity, 1'b1);
      chk("bp id", out_id, 1'b0);
      chk("bp readies", {req0_ready, req1_ready}, 2'b00);
      tick(1);
    end
    out_ready = 1; req1_valid = 0;
    tick(1);
    chk("bp drop", out_valid, 1'b0);

    run_word(0, 8'hFF, 1'b0, "FF");
    run_word(1, 8'h00, 1'b0, "00");
    run_word(0, 8'h80, 1'b1, "80");

    // Reset in the middle of SHIFT discards the word.
    req0_valid = 1; req0_data = 8'hFF;
    tick(1);
    req0_valid = 0;
    tick(3);
    rst = 1; tick(1); rst = 0;
    chk("rst valid", out_valid, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst outs", {out_parity, out_id, req0_ready, req1_ready}, 4'b0);
    n = 0;
    repeat (WIDTH + 3) begin tick(1); if (out_valid) n++; end
    chk("rst no result", n, 0);
    run_word(1, 8'h01, 1'b1, "post-rst 01");

    en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
